// File: rtl/breakpoint_trace_buffer.sv
// Trace event sink: matches events against a programmable breakpoint table, raises a halt
// request on a hit, and logs accepted events into a circular FIFO drained by the debug host.
module breakpoint_trace_buffer #(
  parameter int unsigned ID_WIDTH   = 32,
  parameter int unsigned STMT_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_BP     = 4,
  localparam int unsigned BpIdxW    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int unsigned PtrW      = $clog2(DEPTH),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ev_valid,
  input  logic [ID_WIDTH-1:0]   ev_instance_id,
  input  logic [STMT_WIDTH-1:0] ev_stmt_id,
  input  logic                  bp_wr_en,
  input  logic [BpIdxW-1:0]     bp_wr_idx,
  input  logic                  bp_wr_enable,
  input  logic [ID_WIDTH-1:0]   bp_wr_instance,
  input  logic [STMT_WIDTH-1:0] bp_wr_stmt,
  input  logic                  resume,
  output logic                  halt_req,
  output logic [BpIdxW-1:0]     hit_idx,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ID_WIDTH-1:0]   rd_instance_id,
  output logic [STMT_WIDTH-1:0] rd_stmt_id,
  output logic [CntW-1:0]       count,
  output logic [15:0]           overflow_cnt
);

  localparam int unsigned EntryW = ID_WIDTH + STMT_WIDTH;

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StHalted = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [BpIdxW-1:0]     hit_idx_q, hit_idx_d;

  logic                  bp_en_q   [NUM_BP];
  logic [ID_WIDTH-1:0]   bp_inst_q [NUM_BP];
  logic [STMT_WIDTH-1:0] bp_stmt_q [NUM_BP];

  logic [EntryW-1:0]     mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [15:0]           ovf_q, ovf_d;

  logic                  match;
  logic [BpIdxW-1:0]     match_idx;
  logic                  capture, full, push, pop, drop;
  logic [EntryW-1:0]     head;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
      if (bp_en_q[i] && bp_inst_q[i] == ev_instance_id && bp_stmt_q[i] == ev_stmt_id) begin
        match     = 1'b1;
        match_idx = BpIdxW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hit_idx_d = hit_idx_q;
    case (state_q)
      StRun: begin
        if (ev_valid && match) begin
          state_d   = StHalted;
          hit_idx_d = match_idx;
        end
      end
      StHalted: begin
        if (resume) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign rd_valid = (count_q != '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign capture  = ev_valid && (state_q == StRun);
  assign pop      = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = capture && (!full || pop);
  assign drop     = capture && full && !pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
    ovf_d = ovf_q;
    if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      hit_idx_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= '0;
      for (int i = 0; i < int'(NUM_BP); i++) begin
        bp_en_q[i]   <= 1'b0;
        bp_inst_q[i] <= '0;
        bp_stmt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      hit_idx_q <= hit_idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      // Out-of-range indices decode to no entry and are dropped.
      for (int i = 0; i < int'(NUM_BP); i++) begin
        if (bp_wr_en && bp_wr_idx == BpIdxW'(i)) begin
          bp_en_q[i]   <= bp_wr_enable;
          bp_inst_q[i] <= bp_wr_instance;
          bp_stmt_q[i] <= bp_wr_stmt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ev_instance_id, ev_stmt_id};
  end

  assign head           = mem_q[rd_ptr_q];
  assign rd_instance_id = rd_valid ? head[EntryW-1:STMT_WIDTH] : '0;
  assign rd_stmt_id     = rd_valid ? head[STMT_WIDTH-1:0] : '0;
  assign halt_req       = (state_q == StHalted);
  assign hit_idx        = hit_idx_q;
  assign count          = count_q;
  assign overflow_cnt   = ovf_q;

endmodule

// File: tb/tb_breakpoint_trace_buffer.sv
// Randomized + directed bench for breakpoint_trace_buffer with a queue-based reference model
// and a scoreboard monitor that checks every cycle and every popped entry.
module tb_breakpoint_trace_buffer;

  localparam int unsigned IdW    = 32;
  localparam int unsigned StW    = 32;
  localparam int unsigned Depth  = 16;
  localparam int unsigned NumBp  = 4;
  localparam int unsigned BpIdxW = 2;
  localparam int unsigned CntW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              ev_valid;
  logic [IdW-1:0]    ev_instance_id;
  logic [StW-1:0]    ev_stmt_id;
  logic              bp_wr_en;
  logic [BpIdxW-1:0] bp_wr_idx;
  logic              bp_wr_enable;
  logic [IdW-1:0]    bp_wr_instance;
  logic [StW-1:0]    bp_wr_stmt;
  logic              resume;
  logic              halt_req;
  logic [BpIdxW-1:0] hit_idx;
  logic              rd_valid;
  logic              rd_ready;
  logic [IdW-1:0]    rd_instance_id;
  logic [StW-1:0]    rd_stmt_id;
  logic [CntW-1:0]   count;
  logic [15:0]       overflow_cnt;

  breakpoint_trace_buffer #(
    .ID_WIDTH  (IdW),
    .STMT_WIDTH(StW),
    .DEPTH     (Depth),
    .NUM_BP    (NumBp)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ev_valid      (ev_valid),
    .ev_instance_id(ev_instance_id),
    .ev_stmt_id    (ev_stmt_id),
    .bp_wr_en      (bp_wr_en),
    .bp_wr_idx     (bp_wr_idx),
    .bp_wr_enable  (bp_wr_enable),
    .bp_wr_instance(bp_wr_instance),
    .bp_wr_stmt    (bp_wr_stmt),
    .resume        (resume),
    .halt_req      (halt_req),
    .hit_idx       (hit_idx),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_instance_id(rd_instance_id),
    .rd_stmt_id    (rd_stmt_id),
    .count         (count),
    .overflow_cnt  (overflow_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO contents as a queue, breakpoint table as plain arrays.
  logic [63:0]    exp_q[$];
  logic           m_halted  = 1'b0;
  int unsigned    m_hit     = 0;
  int unsigned    m_ovf     = 0;
  logic           m_bp_en   [NumBp];
  logic [IdW-1:0] m_bp_inst [NumBp];
  logic [StW-1:0] m_bp_stmt [NumBp];
  logic           started   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_halted = 1'b0;
      m_hit    = 0;
      m_ovf    = 0;
      for (int i = 0; i < NumBp; i++) begin
        m_bp_en[i] = 1'b0; m_bp_inst[i] = '0; m_bp_stmt[i] = '0;
      end
      started = 1'b1;
    end else if (started) begin
      if (!m_halted && ev_valid) begin
        for (int i = 0; i < NumBp; i++) begin
          if (!m_halted && m_bp_en[i] && m_bp_inst[i] == ev_instance_id &&
              m_bp_stmt[i] == ev_stmt_id) begin
            m_halted = 1'b1;
            m_hit    = i;
          end
        end
        // The monitor already removed this cycle's popped entry, so size reflects the pop.
        if (exp_q.size() < Depth) exp_q.push_back({ev_instance_id, ev_stmt_id});
        else if (m_ovf < 16'hFFFF) m_ovf++;
      end else if (m_halted && resume) begin
        m_halted = 1'b0;
      end
      if (bp_wr_en && int'(bp_wr_idx) < NumBp) begin
        m_bp_en[bp_wr_idx]   = bp_wr_enable;
        m_bp_inst[bp_wr_idx] = bp_wr_instance;
        m_bp_stmt[bp_wr_idx] = bp_wr_stmt;
      end
    end
  end

  // Scoreboard monitor: status every cycle, head data on every observed pop.
  always @(negedge clk) begin
    if (started) begin
      check("halt_req", halt_req, m_halted);
      check("hit_idx", hit_idx, m_hit);
      check("count", count, exp_q.size());
      check("overflow_cnt", overflow_cnt, m_ovf);
      check("rd_valid", rd_valid, exp_q.size() != 0);
      if (exp_q.size() != 0 && rd_ready) begin
        check("rd_instance_id", rd_instance_id, exp_q[0][63:32]);
        check("rd_stmt_id", rd_stmt_id, exp_q[0][31:0]);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [31:0] id, input logic [31:0] st);
    ev_valid = 1'b1; ev_instance_id = id; ev_stmt_id = st;
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic bp_write(input int idx, input logic en, input logic [31:0] id,
                          input logic [31:0] st);
    bp_wr_en = 1'b1; bp_wr_idx = BpIdxW'(idx); bp_wr_enable = en;
    bp_wr_instance = id; bp_wr_stmt = st;
    tick();
    bp_wr_en = 1'b0;
  endtask

  task automatic do_resume();
    resume = 1'b1;
    tick();
    resume = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ev_valid = 1'b0; ev_instance_id = '0; ev_stmt_id = '0;
    bp_wr_en = 1'b0; bp_wr_idx = '0; bp_wr_enable = 1'b0; bp_wr_instance = '0;
    bp_wr_stmt = '0; resume = 1'b0; rd_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_count", count, 0);
    check("reset_rd_valid", rd_valid, 0);

    // In-order delivery, one cycle after each event.
    ev(1, 0);
    @(negedge clk);
    check("t1_rd_valid", rd_valid, 1);
    check("t1_first_stmt", rd_stmt_id, 0);
    ev(1, 1); ev(1, 2); tick(); tick();
    check("t1_no_halt", halt_req, 0);

    // Breakpoint hit halts; events while halted are ignored.
    rd_ready = 1'b0;
    bp_write(0, 1'b1, 1, 3);
    ev(1, 2); ev(1, 3); ev(1, 4);
    @(negedge clk);
    check("t2_halt", halt_req, 1);
    check("t2_hit_idx", hit_idx, 0);
    check("t2_count", count, 2);
    do_resume();
    ev(1, 5);
    @(negedge clk);
    check("t2_after_resume", count, 3);
    rd_ready = 1'b1;
    repeat (5) tick();
    rd_ready = 1'b0;

    // Overflow, then push with simultaneous pop while full.
    for (int i = 0; i < Depth + 3; i++) ev(7, 100 + i);
    @(negedge clk);
    check("t3_count_full", count, Depth);
    check("t3_overflow", overflow_cnt, 3);
    rd_ready = 1'b1;
    ev(7, 200);
    rd_ready = 1'b0;
    @(negedge clk);
    check("t4_count_full", count, Depth);
    check("t4_overflow", overflow_cnt, 3);
    rd_ready = 1'b1;
    repeat (Depth + 4) tick();

    // Matching uses the table as it was before a same-cycle write.
    bp_write(1, 1'b1, 9, 9);
    bp_write(2, 1'b1, 9, 9);
    bp_wr_en = 1'b1; bp_wr_idx = 2'd1; bp_wr_enable = 1'b0;
    bp_wr_instance = 9; bp_wr_stmt = 9;
    ev(9, 9);
    bp_wr_en = 1'b0;
    @(negedge clk);
    check("t5_halt", halt_req, 1);
    check("t5_hit_idx_1", hit_idx, 1);
    do_resume();
    ev(9, 9);
    @(negedge clk);
    check("t5_hit_idx_2", hit_idx, 2);
    do_resume();
    tick(); tick();

    // Reset while halted with a partly full FIFO.
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) ev(20, i);
    ev(9, 9);
    @(negedge clk);
    check("t6_pre_halt", halt_req, 1);
    check("t6_pre_count", count, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_halt_cleared", halt_req, 0);
    check("t6_rd_valid", rd_valid, 0);
    check("t6_count", count, 0);
    check("t6_overflow", overflow_cnt, 0);
    ev(9, 9);
    @(negedge clk);
    check("t6_bp_cleared", halt_req, 0);
    rd_ready = 1'b1;
    tick();

    // Randomized traffic over a small id space so breakpoints hit often.
    for (int c = 0; c < 4000; c++) begin
      ev_valid       = ($urandom_range(0, 99) < 70);
      ev_instance_id = $urandom_range(0, 3);
      ev_stmt_id     = $urandom_range(0, 3);
      bp_wr_en       = ($urandom_range(0, 9) == 0);
      bp_wr_idx      = BpIdxW'($urandom_range(0, 3));
      bp_wr_enable   = $urandom_range(0, 1);
      bp_wr_instance = $urandom_range(0, 3);
      bp_wr_stmt     = $urandom_range(0, 3);
      resume         = ($urandom_range(0, 5) == 0);
      rd_ready       = ($urandom_range(0, 99) < 40);
      rst            = ($urandom_range(0, 499) == 0);
      tick();
    end
    ev_valid = 1'b0; bp_wr_en = 1'b0; resume = 1'b0; rst = 1'b0; rd_ready = 1'b1;
    repeat (Depth + 2) tick();
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
